// File: rtl/bin2bcd_if.sv
// Handshake and data bundle between the task-number source and the
// sequential binary-to-BCD converter.
interface bin2bcd_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic                  clr;
    logic [WIDTH-1:0]      num;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;
    logic                  ovf;

    // Requester side: issues operands and commands, observes results.
    modport master (
        output start, clr, num,
        input  busy, done, bcd, blank, ovf
    );

    // Converter side.
    modport slave (
        input  start, clr, num,
        output busy, done, bcd, blank, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3). Fixed latency of
// WIDTH+1 clocks from the accepted start edge to the result update, with
// start/busy/done handshake, clear/abort, overflow flag, leading-zero blank
// mask and an optional auto-convert-on-change mode.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter bit AUTO   = 1'b0
) (
    input  logic       clk,
    input  logic       res_n,
    bin2bcd_if.slave   bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);
    // Blank mask of an all-zero result: every digit except digit 0 blanked.
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [WIDTH-1:0]    r_sh;        // operand being shifted out MSB first
    logic [BW-1:0]       r_acc;       // BCD accumulator, hidden until FINISH
    logic                r_ovf_acc;   // any bit lost off the top digit
    logic [CW-1:0]       r_cnt;       // shifts remaining
    logic [WIDTH-1:0]    r_last;      // last operand accepted
    logic                r_first;     // no conversion since reset (AUTO)
    logic                r_busy;
    logic                r_done;
    logic [BW-1:0]       r_bcd;
    logic [DIGITS-1:0]   r_blank;
    logic                r_ovf;

    logic                w_trigger;
    logic                w_load;
    logic                w_shift;
    logic                w_finish;
    logic [BW-1:0]       w_acc_adj;
    logic [DIGITS-1:0]   w_blank;

    // Add-3 correction per digit. A digit is at most 9 here, so the +3 never
    // exceeds 4 bits and no carry crosses into the neighbouring digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign w_acc_adj[4*gi +: 4] = (r_acc[4*gi +: 4] >= 4'd5)
                                        ? r_acc[4*gi +: 4] + 4'd3
                                        : r_acc[4*gi +: 4];
        end
    endgenerate

    // Leading-zero mask from the finished accumulator; digit 0 is never blank.
    always_comb begin
        logic w_hi_zero;
        w_blank   = '0;
        w_hi_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_hi_zero  = w_hi_zero && (r_acc[4*i +: 4] == 4'd0);
            w_blank[i] = w_hi_zero;
        end
    end

    // Conversion request: explicit start, or in AUTO mode a changed operand
    // (or the very first run after reset).
    assign w_trigger = bus.start ||
                       ((AUTO == 1'b1) && ((bus.num != r_last) || r_first));

    // Next-state and step controls; clear forces IDLE and suppresses all steps.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_load       = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_shift = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_finish     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (bus.clr) begin
            w_state_next = S_IDLE;
            w_load       = 1'b0;
            w_shift      = 1'b0;
            w_finish     = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: load operand, shift/correct, publish result on FINISH.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_sh      <= '0;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
            r_cnt     <= '0;
            r_last    <= '0;
            r_first   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= BLANK_RST;
            r_ovf     <= 1'b0;
        end else if (bus.clr) begin
            r_last    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_blank   <= BLANK_RST;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_sh      <= bus.num;
                r_last    <= bus.num;
                r_acc     <= '0;
                r_ovf_acc <= 1'b0;
                r_cnt     <= CW'(WIDTH);
                r_busy    <= 1'b1;
                r_first   <= 1'b0;
            end
            if (w_shift) begin
                r_acc     <= {w_acc_adj[BW-2:0], r_sh[WIDTH-1]};
                r_sh      <= r_sh << 1;
                r_ovf_acc <= r_ovf_acc | w_acc_adj[BW-1];
                r_cnt     <= r_cnt - CW'(1);
            end
            if (w_finish) begin
                r_bcd   <= r_acc;
                r_ovf   <= r_ovf_acc;
                r_blank <= w_blank;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.bcd   = r_bcd;
    assign bus.blank = r_blank;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: a 3-digit and a 2-digit converter share one
// stimulus stream; a third instance exercises AUTO mode on its own.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       res_n;
    logic       tb_start, tb_clr;
    logic [7:0] tb_num;
    logic       c_clr;
    logic [7:0] c_num;

    bin2bcd_if #(.WIDTH(8), .DIGITS(3)) ifa ();
    bin2bcd_if #(.WIDTH(8), .DIGITS(2)) ifb ();
    bin2bcd_if #(.WIDTH(8), .DIGITS(3)) ifc ();

    assign ifa.start = tb_start;
    assign ifa.clr   = tb_clr;
    assign ifa.num   = tb_num;
    assign ifb.start = tb_start;
    assign ifb.clr   = tb_clr;
    assign ifb.num   = tb_num;
    assign ifc.start = 1'b0;
    assign ifc.clr   = c_clr;
    assign ifc.num   = c_num;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .AUTO(1'b0)) dut_a (.clk(clk), .res_n(res_n), .bus(ifa));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(2), .AUTO(1'b0)) dut_b (.clk(clk), .res_n(res_n), .bus(ifb));
    bin2bcd_seq #(.WIDTH(8), .DIGITS(3), .AUTO(1'b1)) dut_c (.clk(clk), .res_n(res_n), .bus(ifc));

    int errors = 0;
    int checks = 0;

    logic [11:0] prev_a;
    logic [7:0]  prev_b;

    // AUTO instance: count done pulses and keep the results they carried
    int          c_done_cnt = 0;
    logic [11:0] c_hist[$];
    always @(posedge clk) begin
        if (ifc.done === 1'b1) begin
            c_done_cnt <= c_done_cnt + 1;
            c_hist.push_back(ifc.bcd);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: decimal digits by division, mod 10^d truncation
    function automatic logic [39:0] m_bcd(input int unsigned n, input int d);
        logic [39:0] r;
        int unsigned v;
        r = '0;
        v = n;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic longint pow10(input int d);
        longint p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p;
    endfunction

    function automatic logic m_ovf(input int unsigned n, input int d);
        return longint'(n) >= pow10(d);
    endfunction

    function automatic logic [9:0] m_blank(input int unsigned n, input int d);
        logic [9:0] b;
        longint m;
        b = '0;
        m = longint'(n) % pow10(d);
        for (int i = 1; i < d; i++) b[i] = ((m / pow10(i)) == 0);
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full conversion on both shared-stimulus instances
    task automatic convert(input logic [7:0] n,
                           input logic [11:0] ea, input logic [2:0] bla, input logic oa,
                           input logic [7:0]  eb, input logic [1:0] blb, input logic ob);
        int cyc;
        int busy_cnt;
        bit stable;
        cyc = 0;
        busy_cnt = 0;
        stable = 1'b1;
        tb_num = n;
        tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        while (ifa.done !== 1'b1 && cyc < 20) begin
            if (ifa.busy === 1'b1) busy_cnt++;
            if (ifa.bcd !== prev_a || ifb.bcd !== prev_b) stable = 1'b0;
            tick();
            cyc++;
        end
        chk("latency", 64'(cyc), 64'd9);
        chk("busy_cycles", 64'(busy_cnt), 64'd9);
        chk("bcd_held", 64'(stable), 64'd1);
        chk("a_busy_at_done", 64'(ifa.busy), 64'd0);
        chk("a_bcd", 64'(ifa.bcd), 64'(ea));
        chk("a_blank", 64'(ifa.blank), 64'(bla));
        chk("a_ovf", 64'(ifa.ovf), 64'(oa));
        chk("b_done", 64'(ifb.done), 64'd1);
        chk("b_bcd", 64'(ifb.bcd), 64'(eb));
        chk("b_blank", 64'(ifb.blank), 64'(blb));
        chk("b_ovf", 64'(ifb.ovf), 64'(ob));
        $display("txn num=%0d bcd3=%03h blank3=%03b ovf3=%0b bcd2=%02h blank2=%02b ovf2=%0b",
                 n, ifa.bcd, ifa.blank, ifa.ovf, ifb.bcd, ifb.blank, ifb.ovf);
        prev_a = ea;
        prev_b = eb;
        tick();
        chk("done_pulse_width", 64'(ifa.done), 64'd0);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_busy"}, 64'(ifa.busy), 64'd0);
        chk({tag, "_done"}, 64'(ifa.done), 64'd0);
        chk({tag, "_bcd"}, 64'(ifa.bcd), 64'd0);
        chk({tag, "_ovf"}, 64'(ifa.ovf), 64'd0);
        chk({tag, "_blank"}, 64'(ifa.blank), 64'b110);
        chk({tag, "_b_blank"}, 64'(ifb.blank), 64'b10);
        chk({tag, "_b_bcd"}, 64'(ifb.bcd), 64'd0);
    endtask

    task automatic watch_no_done(input string name, input int ncyc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            tick();
            if (ifa.done === 1'b1 || ifb.done === 1'b1) seen = 1'b1;
        end
        chk(name, 64'(seen), 64'd0);
    endtask

    typedef struct {
        logic [7:0]  num;
        logic [11:0] bcd3;
        logic [2:0]  blank3;
        logic        ovf3;
        logic [7:0]  bcd2;
        logic [1:0]  blank2;
        logic        ovf2;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        logic [7:0]  rn;
        logic [39:0] w40;
        logic [9:0]  w10;
        logic [11:0] ea;
        logic [7:0]  eb;
        logic [2:0]  bla;
        logic [1:0]  blb;

        vecs[0] = '{8'd255, 12'h255, 3'b000, 1'b0, 8'h55, 2'b00, 1'b1};
        vecs[1] = '{8'd0,   12'h000, 3'b110, 1'b0, 8'h00, 2'b10, 1'b0};
        vecs[2] = '{8'd7,   12'h007, 3'b110, 1'b0, 8'h07, 2'b10, 1'b0};
        vecs[3] = '{8'd42,  12'h042, 3'b100, 1'b0, 8'h42, 2'b00, 1'b0};
        vecs[4] = '{8'd99,  12'h099, 3'b100, 1'b0, 8'h99, 2'b00, 1'b0};
        vecs[5] = '{8'd100, 12'h100, 3'b000, 1'b0, 8'h00, 2'b10, 1'b1};
        vecs[6] = '{8'd10,  12'h010, 3'b100, 1'b0, 8'h10, 2'b00, 1'b0};
        vecs[7] = '{8'd200, 12'h200, 3'b000, 1'b0, 8'h00, 2'b10, 1'b1};

        res_n = 1'b0; tb_start = 1'b0; tb_clr = 1'b0; tb_num = '0;
        c_clr = 1'b0; c_num = '0;
        tick(); tick();
        chk_cleared("reset");
        res_n = 1'b1;
        prev_a = '0;
        prev_b = '0;
        tick();

        // Table-driven conversions
        for (int i = 0; i < 8; i++) begin
            convert(vecs[i].num, vecs[i].bcd3, vecs[i].blank3, vecs[i].ovf3,
                    vecs[i].bcd2, vecs[i].blank2, vecs[i].ovf2);
        end

        // Back-to-back: start on the IDLE edge right after FINISH (period 10)
        tb_num = 8'd42; tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        repeat (8) tick();
        tick();
        chk("b2b_first_done", 64'(ifa.done), 64'd1);
        chk("b2b_first_bcd", 64'(ifa.bcd), 64'h042);
        tb_num = 8'd7; tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        chk("b2b_accepted", 64'(ifa.busy), 64'd1);
        repeat (8) tick();
        tick();
        chk("b2b_second_done", 64'(ifa.done), 64'd1);
        chk("b2b_second_bcd", 64'(ifa.bcd), 64'h007);
        prev_a = 12'h007;
        prev_b = 8'h07;
        tick();

        // Start ignored mid-flight, then clr aborts 4 edges after start
        tb_num = 8'd100; tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        tick();
        tb_num = 8'd5; tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        tick();
        chk("midflight_busy", 64'(ifa.busy), 64'd1);
        tb_clr = 1'b1;
        tick();
        tb_clr = 1'b0;
        chk_cleared("clr");
        prev_a = '0;
        prev_b = '0;
        watch_no_done("clr_no_done", 15);
        convert(8'd100, 12'h100, 3'b000, 1'b0, 8'h00, 2'b10, 1'b1);
        convert(8'd99,  12'h099, 3'b100, 1'b0, 8'h99, 2'b00, 1'b0);

        // Random operands against the reference model
        for (int i = 0; i < 40; i++) begin
            rn  = 8'($urandom_range(0, 255));
            w40 = m_bcd(rn, 3); ea = w40[11:0];
            w40 = m_bcd(rn, 2); eb = w40[7:0];
            w10 = m_blank(rn, 3); bla = w10[2:0];
            w10 = m_blank(rn, 2); blb = w10[1:0];
            convert(rn, ea, bla, m_ovf(rn, 3), eb, blb, m_ovf(rn, 2));
        end

        // Reset mid-conversion, with start and clr also asserted
        tb_num = 8'd255; tb_start = 1'b1;
        tick();
        tb_start = 1'b0;
        repeat (3) tick();
        res_n = 1'b0; tb_start = 1'b1; tb_clr = 1'b1;
        tick();
        chk_cleared("rst_mid");
        res_n = 1'b1; tb_start = 1'b0; tb_clr = 1'b0;
        prev_a = '0;
        prev_b = '0;
        watch_no_done("rst_no_done", 15);

        // AUTO mode
        c_num = 8'd0;
        res_n = 1'b0;
        tick();
        res_n = 1'b1;
        base = c_done_cnt;
        repeat (15) tick();
        chk("auto_first_run", 64'(c_done_cnt - base), 64'd1);
        chk("auto_first_bcd", 64'(ifc.bcd), 64'h000);
        chk("auto_first_blank", 64'(ifc.blank), 64'b110);
        c_num = 8'd200;
        repeat (15) tick();
        chk("auto_change_cnt", 64'(c_done_cnt - base), 64'd2);
        chk("auto_change_bcd", 64'(ifc.bcd), 64'h200);
        repeat (15) tick();
        chk("auto_hold_cnt", 64'(c_done_cnt - base), 64'd2);
        c_num = 8'd13;
        repeat (3) tick();
        c_num = 8'd77;
        repeat (25) tick();
        chk("auto_mid_cnt", 64'(c_done_cnt - base), 64'd4);
        chk("auto_mid_first", 64'(c_hist[c_hist.size() - 2]), 64'h013);
        chk("auto_mid_second", 64'(ifc.bcd), 64'h077);
        c_clr = 1'b1;
        tick();
        c_clr = 1'b0;
        chk("auto_clr_bcd", 64'(ifc.bcd), 64'h000);
        repeat (15) tick();
        chk("auto_clr_reconvert_cnt", 64'(c_done_cnt - base), 64'd5);
        chk("auto_clr_reconvert_bcd", 64'(ifc.bcd), 64'h077);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
